// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions used by the end-of-program monitor.
package mips_pkg;

  localparam int unsigned RUN_W   = 8;
  localparam int unsigned DRAIN_W = 4;

  localparam logic [31:0] MIPS_BREAK_WORD = 32'h0000000D;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } epm_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_ZERO = 2'b01,
    CAUSE_HALT = 2'b10,
    CAUSE_RSVD = 2'b11
  } end_cause_e;

endpackage

// File: rtl/end_program_monitor_if.sv
// Pipeline-side bundle for the end-of-program monitor: IF/ID sample in, status/stats out.
interface end_program_monitor_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
);
  logic              clear;
  logic              enable;
  logic [DATA_W-1:0] instruction_IFID;
  logic              programEnd;
  logic              draining;
  logic [1:0]        endCause;
  logic [CNT_W-1:0]  instrCount;
  logic [CNT_W-1:0]  cycleCount;

  modport master (
    output clear, enable, instruction_IFID,
    input  programEnd, draining, endCause, instrCount, cycleCount
  );

  modport slave (
    input  clear, enable, instruction_IFID,
    output programEnd, draining, endCause, instrCount, cycleCount
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int unsigned   W   = 8,
  parameter logic [W-1:0]  MAX = '1
) (
  input  logic         pipeClk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up until MAX, then hold.
  always_ff @(posedge pipeClk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/end_program_monitor.sv
// End-of-program detector: zero-word run or BREAK word, then drain, then sticky programEnd.
module end_program_monitor
  import mips_pkg::*;
#(
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       ZERO_RUN     = 4,
  parameter int unsigned       CONSECUTIVE  = 1,
  parameter int unsigned       HALT_EN      = 1,
  parameter logic [DATA_W-1:0] HALT_WORD    = DATA_W'(MIPS_BREAK_WORD),
  parameter int unsigned       DRAIN_CYCLES = 4,
  parameter int unsigned       CNT_W        = 32
) (
  input  logic                  pipeClk,
  input  logic                  reset,
  end_program_monitor_if.slave  mon
);

  localparam logic [RUN_W-1:0]   RUN_MAX    = RUN_W'(ZERO_RUN);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = (DRAIN_CYCLES == 0) ? DRAIN_W'(0)
                                                                   : DRAIN_W'(DRAIN_CYCLES - 1);
  localparam bit                 NO_DRAIN   = (DRAIN_CYCLES == 0);
  localparam bit                 CONSEC     = (CONSECUTIVE != 0);
  localparam bit                 HALT_ON    = (HALT_EN != 0);

  epm_state_e         state;
  end_cause_e         cause_q;
  logic               program_end_q;
  logic               draining_q;
  logic [RUN_W-1:0]   zero_run;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [RUN_W-1:0]   zero_run_inc;

  logic accept, is_zero, zero_hit, halt_hit, detect;
  logic run_inc, run_clr, drain_clr, drain_inc, instr_inc, cyc_inc;

  // Word acceptance and detection decode.
  assign accept       = mon.enable && (state == ST_RUN) && !mon.clear;
  assign is_zero      = (mon.instruction_IFID == '0);
  assign zero_run_inc = zero_run + RUN_W'(1);
  assign zero_hit     = accept && is_zero && (zero_run_inc == RUN_MAX);
  assign halt_hit     = accept && HALT_ON && !is_zero && (mon.instruction_IFID == HALT_WORD);
  assign detect       = zero_hit || halt_hit;

  // Counter controls.
  assign run_inc   = accept && is_zero;
  assign run_clr   = mon.clear || (accept && !is_zero && CONSEC);
  assign drain_clr = mon.clear || detect;
  assign drain_inc = (state == ST_DRAIN) && mon.enable;
  assign instr_inc = accept && !is_zero;
  assign cyc_inc   = (state != ST_DONE);

  sat_counter #(.W(RUN_W), .MAX(RUN_MAX)) u_zero_run (
    .pipeClk (pipeClk), .reset (reset), .clr (run_clr), .inc (run_inc), .count (zero_run)
  );

  sat_counter #(.W(DRAIN_W), .MAX(DRAIN_W'(15))) u_drain (
    .pipeClk (pipeClk), .reset (reset), .clr (drain_clr), .inc (drain_inc), .count (drain_cnt)
  );

  sat_counter #(.W(CNT_W)) u_instr (
    .pipeClk (pipeClk), .reset (reset), .clr (mon.clear), .inc (instr_inc), .count (mon.instrCount)
  );

  sat_counter #(.W(CNT_W)) u_cycle (
    .pipeClk (pipeClk), .reset (reset), .clr (mon.clear), .inc (cyc_inc), .count (mon.cycleCount)
  );

  // RUN -> (DRAIN ->) DONE sequencing with registered status outputs.
  always_ff @(posedge pipeClk or posedge reset) begin
    if (reset) begin
      state         <= ST_RUN;
      cause_q       <= CAUSE_NONE;
      program_end_q <= 1'b0;
      draining_q    <= 1'b0;
    end else if (mon.clear) begin
      state         <= ST_RUN;
      cause_q       <= CAUSE_NONE;
      program_end_q <= 1'b0;
      draining_q    <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (detect) begin
            cause_q <= zero_hit ? CAUSE_ZERO : CAUSE_HALT;
            if (NO_DRAIN) begin
              state         <= ST_DONE;
              program_end_q <= 1'b1;
            end else begin
              state      <= ST_DRAIN;
              draining_q <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (mon.enable && (drain_cnt == DRAIN_LAST)) begin
            state         <= ST_DONE;
            draining_q    <= 1'b0;
            program_end_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

  assign mon.programEnd = program_end_q;
  assign mon.draining   = draining_q;
  assign mon.endCause   = cause_q;

endmodule

// File: tb/tb_end_program_monitor.sv
// Directed bench for end_program_monitor: default, cumulative, and no-drain/narrow-counter variants.
module tb_end_program_monitor;

  logic pipeClk = 1'b0;
  logic reset;

  // Group A drives the default and cumulative instances; group B drives the no-drain instance.
  logic        en_a, clr_a;
  logic [31:0] word_a;
  logic        en_b, clr_b;
  logic [31:0] word_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 pipeClk = ~pipeClk;

  end_program_monitor_if #(.DATA_W(32), .CNT_W(32)) if0 ();
  end_program_monitor_if #(.DATA_W(32), .CNT_W(32)) if1 ();
  end_program_monitor_if #(.DATA_W(32), .CNT_W(4))  if2 ();

  assign if0.clear = clr_a;  assign if0.enable = en_a;  assign if0.instruction_IFID = word_a;
  assign if1.clear = clr_a;  assign if1.enable = en_a;  assign if1.instruction_IFID = word_a;
  assign if2.clear = clr_b;  assign if2.enable = en_b;  assign if2.instruction_IFID = word_b;

  end_program_monitor u_dut0 (.pipeClk(pipeClk), .reset(reset), .mon(if0));

  end_program_monitor #(.CONSECUTIVE(0)) u_dut1 (.pipeClk(pipeClk), .reset(reset), .mon(if1));

  end_program_monitor #(.ZERO_RUN(1), .DRAIN_CYCLES(0), .CNT_W(4))
    u_dut2 (.pipeClk(pipeClk), .reset(reset), .mon(if2));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step_a(input logic e, input logic [31:0] w);
    en_a = e; word_a = w;
    @(posedge pipeClk); #1;
  endtask

  task automatic step_b(input logic e, input logic [31:0] w);
    en_b = e; word_b = w;
    @(posedge pipeClk); #1;
  endtask

  initial begin
    reset = 1'b1;
    en_a = 1'b0; clr_a = 1'b0; word_a = '0;
    en_b = 1'b0; clr_b = 1'b0; word_b = '0;
    repeat (2) @(posedge pipeClk);
    #1;
    check_eq("rst_end",   64'(if0.programEnd), 64'd0);
    check_eq("rst_drain", 64'(if0.draining),   64'd0);
    check_eq("rst_cause", 64'(if0.endCause),   64'd0);
    check_eq("rst_instr", 64'(if0.instrCount), 64'd0);
    check_eq("rst_cycle", 64'(if0.cycleCount), 64'd0);
    reset = 1'b0;

    // Four zero words detect, then four enabled drain edges.
    for (int i = 0; i < 4; i++) step_a(1'b1, 32'h0);
    check_eq("z4_drain", 64'(if0.draining),   64'd1);
    check_eq("z4_cause", 64'(if0.endCause),   64'd1);
    check_eq("z4_end",   64'(if0.programEnd), 64'd0);
    check_eq("z4_cycle", 64'(if0.cycleCount), 64'd4);
    for (int i = 0; i < 3; i++) step_a(1'b1, 32'h2008_0001);
    check_eq("z4_d3_end",   64'(if0.programEnd), 64'd0);
    check_eq("z4_d3_instr", 64'(if0.instrCount), 64'd0);
    step_a(1'b1, 32'h2008_0001);
    check_eq("z4_done_end",   64'(if0.programEnd), 64'd1);
    check_eq("z4_done_drain", 64'(if0.draining),   64'd0);
    check_eq("z4_done_cycle", 64'(if0.cycleCount), 64'd8);
    step_a(1'b1, 32'h0);
    check_eq("done_frozen_cycle", 64'(if0.cycleCount), 64'd8);
    check_eq("done_sticky",       64'(if0.programEnd), 64'd1);

    // Clear in DONE restarts everything.
    clr_a = 1'b1;
    step_a(1'b1, 32'h0);
    clr_a = 1'b0;
    check_eq("clr_end",   64'(if0.programEnd), 64'd0);
    check_eq("clr_cause", 64'(if0.endCause),   64'd0);
    check_eq("clr_cycle", 64'(if0.cycleCount), 64'd0);
    check_eq("clr_instr", 64'(if0.instrCount), 64'd0);

    // Three instructions then BREAK; stall during drain.
    step_a(1'b1, 32'h1);
    step_a(1'b1, 32'h2);
    step_a(1'b1, 32'h3);
    step_a(1'b1, 32'h0000_000D);
    check_eq("halt_cause", 64'(if0.endCause),   64'd2);
    check_eq("halt_drain", 64'(if0.draining),   64'd1);
    check_eq("halt_instr", 64'(if0.instrCount), 64'd4);
    check_eq("halt_cycle", 64'(if0.cycleCount), 64'd4);
    for (int i = 0; i < 5; i++) step_a(1'b0, 32'h2008_0001);
    check_eq("stall_end",   64'(if0.programEnd), 64'd0);
    check_eq("stall_drain", 64'(if0.draining),   64'd1);
    check_eq("stall_cycle", 64'(if0.cycleCount), 64'd9);
    for (int i = 0; i < 3; i++) step_a(1'b1, 32'h2008_0001);
    check_eq("halt_d3_end",   64'(if0.programEnd), 64'd0);
    check_eq("halt_d3_instr", 64'(if0.instrCount), 64'd4);
    step_a(1'b1, 32'h2008_0001);
    check_eq("halt_done_end",   64'(if0.programEnd), 64'd1);
    check_eq("halt_done_cause", 64'(if0.endCause),   64'd2);
    check_eq("halt_done_cycle", 64'(if0.cycleCount), 64'd13);

    // Asynchronous reset between edges while in DONE.
    #3;
    reset = 1'b1;
    #1;
    check_eq("areset_end",   64'(if0.programEnd), 64'd0);
    check_eq("areset_cause", 64'(if0.endCause),   64'd0);
    check_eq("areset_instr", 64'(if0.instrCount), 64'd0);
    check_eq("areset_cycle", 64'(if0.cycleCount), 64'd0);
    check_eq("areset_end1",  64'(if1.programEnd), 64'd0);
    #1;
    reset = 1'b0;

    // 0,0,0,X,0,0,0: consecutive does not detect, cumulative detects on the 4th zero.
    step_a(1'b1, 32'h0);
    step_a(1'b1, 32'h0);
    step_a(1'b1, 32'h0);
    step_a(1'b1, 32'h2008_0001);
    check_eq("cum_pre_drain", 64'(if1.draining), 64'd0);
    step_a(1'b1, 32'h0);
    check_eq("cum_drain", 64'(if1.draining),   64'd1);
    check_eq("cum_cause", 64'(if1.endCause),   64'd1);
    check_eq("cum_instr", 64'(if1.instrCount), 64'd1);
    check_eq("con_nodet", 64'(if0.draining),   64'd0);
    step_a(1'b1, 32'h0);
    step_a(1'b1, 32'h0);
    check_eq("con_nodet7", 64'(if0.draining),   64'd0);
    check_eq("con_instr",  64'(if0.instrCount), 64'd1);
    step_a(1'b1, 32'h0);
    check_eq("con_det",   64'(if0.draining), 64'd1);
    check_eq("con_cause", 64'(if0.endCause), 64'd1);
    check_eq("cum_d3_end", 64'(if1.programEnd), 64'd0);
    step_a(1'b1, 32'h0);
    check_eq("cum_end", 64'(if1.programEnd), 64'd1);

    // No-drain, single-zero instance with 4-bit saturating counters.
    en_a = 1'b0;
    clr_b = 1'b1;
    step_b(1'b0, 32'h0);
    clr_b = 1'b0;
    check_eq("nd_clr_cycle", 64'(if2.cycleCount), 64'd0);
    for (int i = 0; i < 14; i++) step_b(1'b1, 32'h2008_0001);
    check_eq("nd_instr14", 64'(if2.instrCount), 64'd14);
    check_eq("nd_cycle14", 64'(if2.cycleCount), 64'd14);
    for (int i = 0; i < 3; i++) step_b(1'b1, 32'h2008_0001);
    check_eq("nd_instr_sat", 64'(if2.instrCount), 64'd15);
    check_eq("nd_cycle_sat", 64'(if2.cycleCount), 64'd15);
    check_eq("nd_pre_end",   64'(if2.programEnd), 64'd0);
    step_b(1'b1, 32'h0);
    check_eq("nd_end",   64'(if2.programEnd), 64'd1);
    check_eq("nd_cause", 64'(if2.endCause),   64'd1);
    check_eq("nd_drain", 64'(if2.draining),   64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
